// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchronizer, mid-bit sampling FSM and a
// one-entry holding register with valid/ack handshake plus error flags.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LIM = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LIM = CW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          sample;
  logic          load, stop_bad;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  assign sample = (baud_cnt == ((state == START) ? HALF_LIM : FULL_LIM));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (sample) state_next = rx_s ? IDLE : DATA;
      DATA:      if (sample && bit_idx == 3'd7) state_next = STOP;
      STOP:      if (sample) state_next = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Counter holds at zero outside the timed states so each phase starts fresh.
  always_comb begin
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    if (state == IDLE || state == WAIT_IDLE || sample)
      baud_next = '0;
    if (state == START)
      bit_next = 3'd0;
    if (state == DATA && sample) begin
      bit_next   = bit_idx + 3'd1;
      shift_next = {rx_s, shift_reg[7:1]};
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    load     = (state == STOP) && sample && rx_s;
    stop_bad = (state == STOP) && sample && !rx_s;
  end

  // A load in the same cycle as rd_ack wins and leaves no overrun behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (load) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
        overrun  <= rx_valid && !rd_ack;
      end else if (rd_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver with CLKS_PER_BIT=8: directed scenarios
// plus randomized frames checked against a frame-level holding-register model.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  // Edges from the drive edge of a start bit to the edge that loads the byte:
  // one edge to capture rx, then HALF + 9*CPB + 2 more.
  localparam int LOAD_OFS = 1 + HALF + 9 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_ack(rd_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   err_pulses = 0;
  int   busy_cycles = 0;
  int   valid_rise_cyc = -1;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) err_pulses <= err_pulses + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (rx_valid && !valid_prev) valid_rise_cyc <= cyc;
    valid_prev <= rx_valid;
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_data;
  bit         exp_valid;
  bit         exp_overrun;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; rx = 1'b1; rd_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_data = 8'h00; exp_valid = 1'b0; exp_overrun = 1'b0;
  endtask

  // Drives start, 8 data bits LSB first and a stop bit, CPB cycles each.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                            input bit ack_at_load, input int abort_at);
    logic [9:0] bits;
    int e;
    bits = {stop_bit, b, 1'b0};
    e = 0;
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      for (int j = 0; j < CPB; j++) begin
        tick();
        e++;
        rd_ack = ack_at_load && (e == LOAD_OFS - 1);
        if (abort_at != 0 && e == abort_at) return;
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_bit, input bit ack_same);
    if (stop_bit) begin
      exp_overrun = exp_valid && !ack_same;
      exp_data    = b;
      exp_valid   = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    if (exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
  endtask

  task automatic test_reset();
    rx = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_async: got data=%h v=%b fe=%b ov=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
    apply_reset();
    repeat (5) tick();
    vectors++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_idle: got data=%h v=%b fe=%b ov=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
  endtask

  task automatic test_single();
    int c0, e0;
    apply_reset();
    c0 = cyc; e0 = err_pulses;
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    model_frame(8'hA5, 1'b1, 1'b0);
    $display("single: sent A5 data=%h valid=%b", rx_data, rx_valid);
    vectors++;
    if (valid_rise_cyc - c0 != LOAD_OFS) begin
      miscompares++;
      $display("FAIL single_latency: got %0d edges, expected %0d", valid_rise_cyc - c0, LOAD_OFS);
    end
    vectors++;
    if (rx_data !== exp_data || rx_valid !== exp_valid || err_pulses != e0) begin
      miscompares++;
      $display("FAIL single_data: got %h/%b err+%0d, expected %h/%b err+0",
               rx_data, rx_valid, err_pulses - e0, exp_data, exp_valid);
    end
    repeat (10) tick();
    vectors++;
    if (rx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_hold: got valid=%b, expected 1", rx_valid);
    end
    pulse_ack();
    vectors++;
    if (rx_valid !== exp_valid || rx_data !== exp_data) begin
      miscompares++;
      $display("FAIL single_ack: got %h/%b, expected %h/%b", rx_data, rx_valid, exp_data, exp_valid);
    end
  endtask

  task automatic test_glitch();
    int b0, e0;
    apply_reset();
    b0 = busy_cycles; e0 = err_pulses;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (20) tick();
    $display("glitch: busy for %0d cycles", busy_cycles - b0);
    vectors++;
    if (busy_cycles - b0 != HALF) begin
      miscompares++;
      $display("FAIL glitch_busy: got %0d busy cycles, expected %0d", busy_cycles - b0, HALF);
    end
    vectors++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00 || err_pulses != e0) begin
      miscompares++;
      $display("FAIL glitch_out: got busy=%b v=%b data=%h err+%0d, expected 0/0/00/0",
               busy, rx_valid, rx_data, err_pulses - e0);
    end
  endtask

  task automatic test_frame_err();
    int e0;
    apply_reset();
    e0 = err_pulses;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    repeat (20) tick();
    $display("frame_err: sent 3C bad stop, pulses=%0d", err_pulses - e0);
    vectors++;
    if (err_pulses - e0 != 1 || rx_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_pulse: got pulses=%0d v=%b busy=%b, expected 1/0/1",
               err_pulses - e0, rx_valid, busy);
    end
    rx = 1'b1;
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_recover: got busy=%b v=%b, expected 0/0", busy, rx_valid);
    end
    send_frame(8'h0F, 1'b1, 1'b0, 0);
    model_frame(8'h0F, 1'b1, 1'b0);
    $display("frame_err: sent 0F data=%h valid=%b", rx_data, rx_valid);
    vectors++;
    if (rx_data !== exp_data || rx_valid !== exp_valid || err_pulses - e0 != 1) begin
      miscompares++;
      $display("FAIL ferr_next: got %h/%b pulses=%0d, expected %h/%b pulses=1",
               rx_data, rx_valid, err_pulses - e0, exp_data, exp_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_frame(8'h11, 1'b1, 1'b0, 0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    model_frame(8'h22, 1'b1, 1'b0);
    $display("b2b: sent 11,22 data=%h valid=%b overrun=%b", rx_data, rx_valid, overrun);
    vectors++;
    if (rx_data !== exp_data || rx_valid !== exp_valid || overrun !== exp_overrun) begin
      miscompares++;
      $display("FAIL b2b_overrun: got %h/%b/%b, expected %h/%b/%b",
               rx_data, rx_valid, overrun, exp_data, exp_valid, exp_overrun);
    end
    pulse_ack();
    vectors++;
    if (rx_data !== exp_data || rx_valid !== exp_valid || overrun !== exp_overrun) begin
      miscompares++;
      $display("FAIL b2b_ack: got %h/%b/%b, expected %h/%b/%b",
               rx_data, rx_valid, overrun, exp_data, exp_valid, exp_overrun);
    end
  endtask

  task automatic test_ack_at_load();
    apply_reset();
    send_frame(8'h11, 1'b1, 1'b0, 0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    model_frame(8'h22, 1'b1, 1'b1);
    $display("ack_at_load: sent 22 data=%h valid=%b overrun=%b", rx_data, rx_valid, overrun);
    vectors++;
    if (rx_data !== exp_data || rx_valid !== exp_valid || overrun !== exp_overrun) begin
      miscompares++;
      $display("FAIL ackload: got %h/%b/%b, expected %h/%b/%b",
               rx_data, rx_valid, overrun, exp_data, exp_valid, exp_overrun);
    end
    // A sticky overrun is also cleared when the ack lands on a load.
    send_frame(8'h33, 1'b1, 1'b0, 0);
    model_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1, 0);
    model_frame(8'h44, 1'b1, 1'b1);
    vectors++;
    if (rx_data !== exp_data || rx_valid !== exp_valid || overrun !== exp_overrun) begin
      miscompares++;
      $display("FAIL ackload_clear: got %h/%b/%b, expected %h/%b/%b",
               rx_data, rx_valid, overrun, exp_data, exp_valid, exp_overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    apply_reset();
    send_frame(8'h99, 1'b1, 1'b0, 0);
    e0 = err_pulses;
    send_frame(8'h77, 1'b1, 1'b0, 5 * CPB + HALF);
    rst = 1'b1;
    #1;
    vectors++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL midrst_out: got data=%h v=%b fe=%b ov=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
    rx = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_data = 8'h00; exp_valid = 1'b0; exp_overrun = 1'b0;
    repeat (3) tick();
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    model_frame(8'h5A, 1'b1, 1'b0);
    $display("midrst: sent 5A data=%h valid=%b", rx_data, rx_valid);
    vectors++;
    if (rx_data !== exp_data || rx_valid !== exp_valid || overrun !== exp_overrun
        || err_pulses != e0) begin
      miscompares++;
      $display("FAIL midrst_next: got %h/%b/%b err+%0d, expected %h/%b/%b err+0",
               rx_data, rx_valid, overrun, err_pulses - e0, exp_data, exp_valid, exp_overrun);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit stop_ok, ack_same;
    int e0;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      ack_same = stop_ok && ($urandom_range(0, 3) == 0);
      e0 = err_pulses;
      send_frame(b, stop_ok, ack_same, 0);
      model_frame(b, stop_ok, ack_same);
      if (!stop_ok) begin
        repeat ($urandom_range(0, 15)) tick();
        rx = 1'b1;
        repeat (3) tick();
      end
      $display("rand %0d: byte=%h stop=%0d ack=%0d -> data=%h valid=%b overrun=%b",
               n, b, stop_ok, ack_same, rx_data, rx_valid, overrun);
      vectors++;
      if (rx_data !== exp_data || rx_valid !== exp_valid || overrun !== exp_overrun
          || err_pulses - e0 != (stop_ok ? 0 : 1)) begin
        miscompares++;
        $display("FAIL rand_frame %0d: got %h/%b/%b err+%0d, expected %h/%b/%b err+%0d",
                 n, rx_data, rx_valid, overrun, err_pulses - e0,
                 exp_data, exp_valid, exp_overrun, stop_ok ? 0 : 1);
      end
      if ($urandom_range(0, 1) == 1) pulse_ack();
      repeat ($urandom_range(0, 5)) tick();
    end
    vectors++;
    if (rx_valid !== exp_valid || overrun !== exp_overrun) begin
      miscompares++;
      $display("FAIL rand_final: got %b/%b, expected %b/%b", rx_valid, overrun, exp_valid, exp_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ack_at_load();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage: the downstream consumer of the line driven by uart_transmitter, also used on the external RX pin.
- Frame format: 8N1, LSB first. Oversamples rx with a baud counter and verifies the start bit at mid-bit.
- Holds each received byte in a one-entry holding register with a valid/ack handshake.
- Flags framing errors and overruns to the host logic.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200). Must be >= 4. HALF = floor(CLKS_PER_BIT/2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_ack  input  1  consumer acknowledges rx_data. Single-cycle pulse.
- rx_data  output  8  last good received byte.
- rx_valid  output  1  level. Holding register full; held until rd_ack.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky. A new byte overwrote an unacknowledged one.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - Both synchronizer flops = 1.
  - Baud counter, bit index and shift register = 0.
  - rx_data=0x00; rx_valid, frame_err, overrun, busy = 0.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Baud counter counts 0..limit, then wraps to 0. The sample cycle is the cycle in which the counter equals limit.
- Bit index is 3 bits (0..7).
- IDLE:
  - rx_s==0: go to START, counter=0.
  - Otherwise stay.
- START (limit HALF-1):
  - At the sample cycle, rx_s==0: go to DATA, counter=0, bit index=0.
  - rx_s==1: glitch; return to IDLE, no output change.
- DATA (limit CLKS_PER_BIT-1):
  - At each sample cycle, shift rx_s into shift register MSB; after 8 samples the first bit sits in bit 0.
  - After bit index 7 is sampled, go to STOP.
- STOP (limit CLKS_PER_BIT-1). At the sample cycle:
  - rx_s==1: rx_data <= shift register, rx_valid <= 1, go to IDLE.
  - rx_s==0: frame_err=1 for exactly one cycle, byte discarded, rx_data/rx_valid unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break or stuck-low line re-triggering.
- Latency: rx_valid rises in the cycle after the stop-bit sample cycle.
  - Total from the synchronized falling edge: HALF + 9*CLKS_PER_BIT cycles (+2 for the synchronizer).
- Handshake:
  - rd_ack while rx_valid=1: clears rx_valid and overrun on the next edge. rx_data is retained.
  - rd_ack while rx_valid=0: ignored.
- Simultaneous events:
  - Load with rx_valid=1 and no rd_ack: rx_data overwritten with the new byte, rx_valid stays 1, overrun <= 1.
  - Load with rd_ack in the same cycle: load wins. rx_valid stays 1, rx_data = new byte, overrun not set (cleared if previously set).
- Back-to-back frames: a start bit immediately following the stop bit must be accepted. IDLE detects it on the first rx_s==0 cycle.
- Reset mid-frame: immediate return to reset values. The partial byte is lost and no flags are raised.

Test Plan (CLKS_PER_BIT=8, HALF=4):
1. Idle rx=1, send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> rx_data=0xA5, rx_valid=1 exactly HALF+72+2 cycles after the rx fall, frame_err=0; rx_valid held until rd_ack, then 0.
2. rx low for 3 cycles then high -> busy pulses, returns IDLE; rx_valid, frame_err and rx_data (0x00) unchanged.
3. Frame 0x3C with stop=0, rx held low 20 more cycles, then frame 0x0F -> one frame_err pulse, rx_valid=0 until 0x0F completes, then rx_data=0x0F, rx_valid=1.
4. Back-to-back 0x11 then 0x22 with no rd_ack -> rx_data=0x22, rx_valid=1, overrun=1; rd_ack -> rx_valid=0, overrun=0, rx_data still 0x22.
5. rd_ack asserted in the exact load cycle of the second byte 0x22 (first 0x11 pending) -> rx_valid=1, overrun=0, rx_data=0x22.
6. rst pulsed during DATA bit 4 of 0x77 -> all outputs 0, busy=0; next frame 0x5A received correctly with no frame_err.
